sram_arbiter_ctrl: RTL and testbench

- Sequences the single asynchronous 32-bit base SRAM (1M words, byte enables, active-low ce/oe/we) for the CPU.
- Shares the SRAM between the instruction-fetch port (read-only) and the memory-stage port (read/write), with fixed priority to the memory stage.
- Converts req/ack handshakes into SRAM cycles with programmable read-wait and write-pulse widths.
- Owns the tri-state drive of ram_data.
- Sits between the pipeline's IF/MEM stages and the board SRAM pins.

---
 rtl/sram_arbiter_ctrl_pkg.sv | 34 +++
 rtl/sram_arbiter_ctrl_if.sv | 40 ++++
 rtl/sram_arbiter_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_sram_arbiter_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arbiter_ctrl_pkg.sv
// Shared types for the SRAM arbiter/controller.
//   Word_t       : 32-bit SRAM data word
//   Ram_addr_t   : 20-bit SRAM word address (1M words)
//   Bit_t        : single control bit
//   HIGH_WORD    : released (high-Z) value for the SRAM data bus
//   Sram_state_t : access sequencer states
//   Sram_grant_t : which requester owns the current access
package sram_arbiter_ctrl_pkg;

    typedef logic [31:0] Word_t;
    typedef logic [19:0] Ram_addr_t;
    typedef logic        Bit_t;

    localparam Word_t HIGH_WORD = 32'hzzzz_zzzz;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWrSetup,
        StWrPulse,
        StWrHold,
        StDone
    } Sram_state_t;

    typedef enum logic {
        GRANT_IF,
        GRANT_MEM
    } Sram_grant_t;

    function automatic int unsigned max_cycles(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sram_arbiter_ctrl_if.sv
// Bus bundle between the pipeline IF/MEM stages, the arbiter and the SRAM pins.
//   if_*   : fetch port (read-only req/ack handshake)
//   mem_*  : data port (read/write req/ack handshake)
//   ram_*  : registered SRAM address and active-low strobes (data bus is a separate inout)
// Modports: slave = arbiter view, master = requester/board view.
interface sram_arbiter_ctrl_if;
    import sram_arbiter_ctrl_pkg::*;

    Bit_t      if_req;
    Ram_addr_t if_addr;
    Bit_t      if_ack;
    Word_t     if_rdata;

    Bit_t      mem_req;
    Bit_t      mem_we;
    Ram_addr_t mem_addr;
    logic [3:0] mem_be;
    Word_t     mem_wdata;
    Bit_t      mem_ack;
    Word_t     mem_rdata;

    Ram_addr_t ram_addr;
    logic [3:0] ram_be_n;
    Bit_t      ram_ce_n;
    Bit_t      ram_oe_n;
    Bit_t      ram_we_n;

    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output if_ack, if_rdata, mem_ack, mem_rdata,
        output ram_addr, ram_be_n, ram_ce_n, ram_oe_n, ram_we_n
    );

    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  if_ack, if_rdata, mem_ack, mem_rdata,
        input  ram_addr, ram_be_n, ram_ce_n, ram_oe_n, ram_we_n
    );

endinterface

// File: rtl/sram_arbiter_ctrl.sv
// Sequences the asynchronous 32-bit SRAM for the CPU, arbitrating between the
// fetch port and the memory-stage port (memory stage has fixed priority).
// Ports:
//   clk      : system clock
//   rst_n    : asynchronous active-low reset; drops any access in flight
//   bus      : requester handshakes and registered SRAM address/strobes
//   ram_data : SRAM data bus, driven only while in a write state
// Parameters:
//   READ_CYCLES : cycles ce_n/oe_n are held low before read data is sampled (>= 1)
//   WRITE_PULSE : cycles we_n is held low (>= 1)
module sram_arbiter_ctrl
    import sram_arbiter_ctrl_pkg::*;
#(
    parameter int unsigned READ_CYCLES = 2,
    parameter int unsigned WRITE_PULSE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    sram_arbiter_ctrl_if.slave bus,
    inout  wire [31:0]         ram_data
);

    localparam int unsigned MaxCycles = max_cycles(READ_CYCLES, WRITE_PULSE);
    localparam int unsigned CntW      = $clog2(MaxCycles) + 1;

    typedef logic [CntW-1:0] cnt_t;

    localparam cnt_t RdLast = cnt_t'(READ_CYCLES - 1);
    localparam cnt_t WrLast = cnt_t'(WRITE_PULSE - 1);

    Sram_state_t state_q, state_d;
    Sram_grant_t grant_q, grant_d;
    cnt_t        cnt_q, cnt_d;
    Ram_addr_t   addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    Word_t       wdata_q, wdata_d;
    Bit_t        if_ack_q, if_ack_d;
    Bit_t        mem_ack_q, mem_ack_d;
    Word_t       if_rdata_q, if_rdata_d;
    Word_t       mem_rdata_q, mem_rdata_d;
    Bit_t        ce_n_q, ce_n_d;
    Bit_t        oe_n_q, oe_n_d;
    Bit_t        we_n_q, we_n_d;
    logic [3:0]  be_n_q, be_n_d;
    Bit_t        ram_drive_q, ram_drive_d;

    // Next-state and datapath.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_ack_d    = 1'b0;
        mem_ack_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.mem_req) begin
                    grant_d = GRANT_MEM;
                    addr_d  = bus.mem_addr;
                    be_d    = bus.mem_be;
                    wdata_d = bus.mem_wdata;
                    cnt_d   = '0;
                    state_d = bus.mem_we ? StWrSetup : StRd;
                end else if (bus.if_req) begin
                    grant_d = GRANT_IF;
                    addr_d  = bus.if_addr;
                    cnt_d   = '0;
                    state_d = StRd;
                end
            end
            StRd: begin
                if (cnt_q == RdLast) begin
                    // Sample on the closing edge of the last oe_n-low cycle.
                    if (grant_q == GRANT_MEM) begin
                        mem_rdata_d = ram_data;
                        mem_ack_d   = 1'b1;
                    end else begin
                        if_rdata_d = ram_data;
                        if_ack_d   = 1'b1;
                    end
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWrSetup: begin
                cnt_d   = '0;
                state_d = StWrPulse;
            end
            StWrPulse: begin
                if (cnt_q == WrLast) begin
                    state_d = StWrHold;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWrHold: begin
                mem_ack_d = 1'b1;
                state_d   = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // SRAM pins are a pure function of the next state so they change on the same edge.
    always_comb begin
        ce_n_d      = 1'b1;
        oe_n_d      = 1'b1;
        we_n_d      = 1'b1;
        be_n_d      = 4'b1111;
        ram_drive_d = 1'b0;

        unique case (state_d)
            StRd: begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
                be_n_d = 4'b0000;
            end
            StWrSetup, StWrHold: begin
                ce_n_d      = 1'b0;
                be_n_d      = ~be_d;
                ram_drive_d = 1'b1;
            end
            StWrPulse: begin
                ce_n_d      = 1'b0;
                we_n_d      = 1'b0;
                be_n_d      = ~be_d;
                ram_drive_d = 1'b1;
            end
            default: begin
                ce_n_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            grant_q     <= GRANT_IF;
            cnt_q       <= '0;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            be_n_q      <= 4'b1111;
            ram_drive_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            if_ack_q    <= if_ack_d;
            mem_ack_q   <= mem_ack_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            be_n_q      <= be_n_d;
            ram_drive_q <= ram_drive_d;
        end
    end

    assign bus.if_ack    = if_ack_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.mem_ack   = mem_ack_q;
    assign bus.mem_rdata = mem_rdata_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_be_n  = be_n_q;
    assign bus.ram_ce_n  = ce_n_q;
    assign bus.ram_oe_n  = oe_n_q;
    assign bus.ram_we_n  = we_n_q;

    assign ram_data = ram_drive_q ? wdata_q : HIGH_WORD;

endmodule

// File: tb/tb_sram_arbiter_ctrl.sv
// Scoreboard bench: two arbiters (default timing and READ_CYCLES=4/WRITE_PULSE=3),
// each with a small SRAM model; drivers push expected acks, a negedge monitor checks them.
module tb_sram_arbiter_ctrl;
    import sram_arbiter_ctrl_pkg::*;

    localparam int R0 = 2;
    localparam int W0 = 1;
    localparam int R1 = 4;
    localparam int W1 = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    wire [31:0] ram_data0;
    wire [31:0] ram_data1;

    sram_arbiter_ctrl_if bus0 ();
    sram_arbiter_ctrl_if bus1 ();

    sram_arbiter_ctrl #(.READ_CYCLES(R0), .WRITE_PULSE(W0)) d0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0), .ram_data(ram_data0)
    );
    sram_arbiter_ctrl #(.READ_CYCLES(R1), .WRITE_PULSE(W1)) d1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .ram_data(ram_data1)
    );

    // SRAM models (256 words decoded).
    logic [31:0] mem0 [256];
    logic [31:0] mem1 [256];

    assign ram_data0 = (!bus0.ram_ce_n && !bus0.ram_oe_n) ? mem0[bus0.ram_addr[7:0]] : 'z;
    assign ram_data1 = (!bus1.ram_ce_n && !bus1.ram_oe_n) ? mem1[bus1.ram_addr[7:0]] : 'z;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem0[i] = 32'h0;
            mem1[i] = 32'h0;
        end
        mem0[8'h10] = 32'hDEAD_BEEF;
        mem0[8'h20] = 32'h1122_3344;
        mem0[8'h30] = 32'hCAFE_F00D;
        mem0[8'h40] = 32'h1234_5678;
        mem1[8'h50] = 32'hA5A5_5A5A;
        forever begin
            @(posedge clk);
            if (rst_n && !bus0.ram_ce_n && !bus0.ram_we_n) begin
                for (int b = 0; b < 4; b++)
                    if (!bus0.ram_be_n[b])
                        mem0[bus0.ram_addr[7:0]][b*8 +: 8] = ram_data0[b*8 +: 8];
            end
            if (rst_n && !bus1.ram_ce_n && !bus1.ram_we_n) begin
                for (int b = 0; b < 4; b++)
                    if (!bus1.ram_be_n[b])
                        mem1[bus1.ram_addr[7:0]][b*8 +: 8] = ram_data1[b*8 +: 8];
            end
        end
    end

    typedef struct {
        bit          is_mem;
        bit          chk_data;
        logic [31:0] data;
        int          cyc;
        int          oe;
        int          we;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];

    int errors = 0;
    int checks = 0;
    int oe_cnt[2];
    int we_cnt[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic mon(input int d, input logic ifa, input logic [31:0] ifd, input logic ma,
                       input logic [31:0] md, input logic ce_n, input logic oe_n,
                       input logic we_n, input logic drive);
        exp_t e;
        logic [31:0] act;
        checks++;
        if (!oe_n && !we_n) begin
            errors++;
            $display("FAIL strobes d%0d cyc %0d: oe_n=%b we_n=%b, required not both low",
                     d, cyc, oe_n, we_n);
        end
        checks++;
        if (drive !== (!ce_n && oe_n)) begin
            errors++;
            $display("FAIL drive d%0d cyc %0d: drive=%b ce_n=%b oe_n=%b, required write state only",
                     d, cyc, drive, ce_n, oe_n);
        end
        if (!rst_n) begin
            oe_cnt[d] = 0;
            we_cnt[d] = 0;
            return;
        end
        if (!oe_n) oe_cnt[d]++;
        if (!we_n) we_cnt[d]++;
        if (ifa || ma) begin
            checks++;
            if (ifa && ma) begin
                errors++;
                $display("FAIL both_acks d%0d cyc %0d: if_ack=1 mem_ack=1, required one", d, cyc);
            end
            checks++;
            if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
                errors++;
                $display("FAIL spurious_ack d%0d cyc %0d: ack with nothing pending", d, cyc);
            end else begin
                if (d == 0) e = sb0.pop_front();
                else        e = sb1.pop_front();
                if (ma !== e.is_mem) begin
                    errors++;
                    $display("FAIL ack_port d%0d cyc %0d: mem_ack=%b, required %b",
                             d, cyc, ma, e.is_mem);
                end
                act = e.is_mem ? md : ifd;
                if (e.chk_data) chk($sformatf("rdata d%0d", d), act, e.data);
                chk($sformatf("ack_cycle d%0d", d), cyc, e.cyc);
                chk($sformatf("oe_low_cycles d%0d", d), oe_cnt[d], e.oe);
                chk($sformatf("we_low_cycles d%0d", d), we_cnt[d], e.we);
            end
            oe_cnt[d] = 0;
            we_cnt[d] = 0;
        end
    endtask

    always @(negedge clk) begin
        mon(0, bus0.if_ack, bus0.if_rdata, bus0.mem_ack, bus0.mem_rdata,
            bus0.ram_ce_n, bus0.ram_oe_n, bus0.ram_we_n, d0.ram_drive_q);
        mon(1, bus1.if_ack, bus1.if_rdata, bus1.mem_ack, bus1.mem_rdata,
            bus1.ram_ce_n, bus1.ram_oe_n, bus1.ram_we_n, d1.ram_drive_q);
    end

    task automatic push(input int d, input bit is_mem, input bit chk_data,
                        input logic [31:0] data, input int c, input int oe, input int we);
        exp_t e;
        e.is_mem   = is_mem;
        e.chk_data = chk_data;
        e.data     = data;
        e.cyc      = c;
        e.oe       = oe;
        e.we       = we;
        if (d == 0) sb0.push_back(e);
        else        sb1.push_back(e);
    endtask

    task automatic set_if(input int d, input logic req, input logic [19:0] addr);
        if (d == 0) begin
            bus0.if_req  = req;
            bus0.if_addr = addr;
        end else begin
            bus1.if_req  = req;
            bus1.if_addr = addr;
        end
    endtask

    task automatic set_mem(input int d, input logic req, input logic we, input logic [19:0] addr,
                           input logic [3:0] be, input logic [31:0] wdata);
        if (d == 0) begin
            bus0.mem_req = req; bus0.mem_we = we; bus0.mem_addr = addr;
            bus0.mem_be  = be;  bus0.mem_wdata = wdata;
        end else begin
            bus1.mem_req = req; bus1.mem_we = we; bus1.mem_addr = addr;
            bus1.mem_be  = be;  bus1.mem_wdata = wdata;
        end
    endtask

    // Waits for the ack, then returns one cycle later (posedge + 1) like a real requester.
    task automatic wait_ack(input int d, input bit is_mem, input string what);
        bit got = 1'b0;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            if (d == 0) got = is_mem ? bus0.mem_ack : bus0.if_ack;
            else        got = is_mem ? bus1.mem_ack : bus1.if_ack;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL timeout %s: no ack within 64 cycles, required ack", what);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input int d, input bit is_mem, input logic [19:0] addr,
                           input logic [31:0] exp, input string what);
        int r = (d == 0) ? R0 : R1;
        push(d, is_mem, 1'b1, exp, cyc + 1 + r, r, 0);
        if (is_mem) set_mem(d, 1'b1, 1'b0, addr, 4'h0, 32'h0);
        else        set_if(d, 1'b1, addr);
        wait_ack(d, is_mem, what);
        if (is_mem) set_mem(d, 1'b0, 1'b0, 20'h0, 4'h0, 32'h0);
        else        set_if(d, 1'b0, 20'h0);
    endtask

    task automatic do_write(input int d, input logic [19:0] addr, input logic [3:0] be,
                            input logic [31:0] wdata, input string what);
        int w = (d == 0) ? W0 : W1;
        push(d, 1'b1, 1'b0, 32'h0, cyc + 3 + w, 0, w);
        set_mem(d, 1'b1, 1'b1, addr, be, wdata);
        wait_ack(d, 1'b1, what);
        set_mem(d, 1'b0, 1'b0, 20'h0, 4'h0, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        set_if(0, 1'b0, 20'h0);
        set_if(1, 1'b0, 20'h0);
        set_mem(0, 1'b0, 1'b0, 20'h0, 4'h0, 32'h0);
        set_mem(1, 1'b0, 1'b0, 20'h0, 4'h0, 32'h0);

        // Asynchronous reset takes effect before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("rst ce_n", {31'h0, bus0.ram_ce_n}, 32'h1);
        chk("rst oe_n", {31'h0, bus0.ram_oe_n}, 32'h1);
        chk("rst we_n", {31'h0, bus0.ram_we_n}, 32'h1);
        chk("rst be_n", {28'h0, bus0.ram_be_n}, 32'hF);
        chk("rst addr", {12'h0, bus0.ram_addr}, 32'h0);
        chk("rst acks", {30'h0, bus0.if_ack, bus0.mem_ack}, 32'h0);
        chk("rst rdata", bus0.if_rdata | bus0.mem_rdata, 32'h0);
        chk("rst d1 strobes", {29'h0, bus1.ram_ce_n, bus1.ram_oe_n, bus1.ram_we_n}, 32'h7);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Default timing: fetch read, byte write, read-back, back-to-back reads.
        do_read(0, 1'b0, 20'h00010, 32'hDEAD_BEEF, "if_read");
        do_write(0, 20'h00020, 4'b0010, 32'h0000_AB00, "mem_byte_write");
        do_read(0, 1'b1, 20'h00020, 32'h1122_AB44, "mem_read_back");
        do_read(0, 1'b0, 20'h00040, 32'h1234_5678, "if_back_to_back");

        // Simultaneous requests: memory stage first, fetch served after DONE and IDLE.
        push(0, 1'b1, 1'b1, 32'hCAFE_F00D, cyc + 1 + R0, R0, 0);
        push(0, 1'b0, 1'b1, 32'h1234_5678, cyc + 3 + 2 * R0, R0, 0);
        set_mem(0, 1'b1, 1'b0, 20'h00030, 4'h0, 32'h0);
        set_if(0, 1'b1, 20'h00040);
        wait_ack(0, 1'b1, "sim_mem");
        set_mem(0, 1'b0, 1'b0, 20'h0, 4'h0, 32'h0);
        wait_ack(0, 1'b0, "sim_if");
        set_if(0, 1'b0, 20'h0);

        // Reset in the last RD cycle: strobes released at once, no ack, rdata cleared.
        set_if(0, 1'b1, 20'h00010);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrd ce_n", {31'h0, bus0.ram_ce_n}, 32'h1);
        chk("midrd oe_n", {31'h0, bus0.ram_oe_n}, 32'h1);
        chk("midrd drive", {31'h0, d0.ram_drive_q}, 32'h0);
        chk("midrd if_rdata", bus0.if_rdata, 32'h0);
        set_if(0, 1'b0, 20'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_read(0, 1'b0, 20'h00010, 32'hDEAD_BEEF, "if_reread");

        // Slow timing instance.
        do_read(1, 1'b0, 20'h00050, 32'hA5A5_5A5A, "d1_if_read");
        do_write(1, 20'h00060, 4'b1111, 32'h0102_0304, "d1_full_write");
        do_write(1, 20'h00060, 4'b1001, 32'hAABB_CCDD, "d1_partial_write");
        do_read(1, 1'b1, 20'h00060, 32'hAA02_03DD, "d1_mem_read");

        repeat (4) @(posedge clk);
        chk("scoreboard_drained", sb0.size() + sb1.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
